// File: rtl/alu_pkg.sv
// Shared constants for the ALU command driver: opcodes, flag bit positions and FSM encoding.
package alu_pkg;

  localparam int unsigned OP_W  = 3;
  localparam int unsigned FLG_W = 4;
  localparam int unsigned CNT_W = 4;

  localparam logic [OP_W-1:0] OP_ADD   = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB   = 3'd1;
  localparam logic [OP_W-1:0] OP_AND   = 3'd2;
  localparam logic [OP_W-1:0] OP_OR    = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR   = 3'd4;
  localparam logic [OP_W-1:0] OP_RSVD  = 3'd5;
  localparam logic [OP_W-1:0] OP_SHL_A = 3'd6;
  localparam logic [OP_W-1:0] OP_SHL_B = 3'd7;

  localparam int unsigned FLG_CARRY = 3;
  localparam int unsigned FLG_ZERO  = 2;
  localparam int unsigned FLG_VALID = 1;
  localparam int unsigned FLG_SLT   = 0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // True for opcodes that are forwarded to the ALU; the reserved code is rejected.
  function automatic logic op_drives_alu(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL_A, OP_SHL_B: return 1'b1;
      OP_RSVD: return 1'b0;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_drv_rsp_reg.sv
// Response holding register: captures a result on load and holds it until the
// consumer completes the valid/ready handshake.
module alu_drv_rsp_reg
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic [FLG_W-1:0] load_flags,
  input  logic             load_err,
  input  logic             rsp_ready,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic [FLG_W-1:0] rsp_flags,
  output logic             rsp_err
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [FLG_W-1:0] flags_q, flags_d;
  logic             err_q, err_d;

  // Payload only changes on load, so it stays stable for the whole handshake.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    flags_d = flags_q;
    err_d   = err_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      flags_d = load_flags;
      err_d   = load_err;
    end else if (valid_q && rsp_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

  assign rsp_valid = valid_q;
  assign rsp_data  = data_q;
  assign rsp_flags = flags_q;
  assign rsp_err   = err_q;

endmodule

// File: rtl/alu_cmd_driver.sv
// Initiator for the combinational ALU: accepts one command, drives the ALU pins for
// SAMPLE_DLY+1 cycles, samples result/flags and returns them on the response stream.
module alu_cmd_driver
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned OPCODE     = 3,
  parameter int unsigned SAMPLE_DLY = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OPCODE-1:0] cmd_op,
  input  logic [WIDTH-1:0]  cmd_a,
  input  logic [WIDTH-1:0]  cmd_b,
  input  logic              cmd_chain,
  output logic [WIDTH-1:0]  alu_data_in1,
  output logic [WIDTH-1:0]  alu_data_in2,
  output logic [OPCODE-1:0] alu_op_code,
  output logic              alu_valid_data,
  input  logic [WIDTH-1:0]  alu_data_out,
  input  logic              alu_carry_out,
  input  logic              alu_zero_flag,
  input  logic              alu_valid_flag,
  input  logic              alu_slt_flag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_data,
  output logic [FLG_W-1:0]  rsp_flags,
  output logic              rsp_err
);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  last_q, last_d;
  logic [WIDTH-1:0]  in1_q, in1_d;
  logic [WIDTH-1:0]  in2_q, in2_d;
  logic [OPCODE-1:0] op_q, op_d;
  logic              vld_q, vld_d;

  logic              accept_c;
  logic              sample_done_c;
  logic              rsp_hs_c;
  logic [FLG_W-1:0]  alu_flags_c;
  logic              rsp_load_c;
  logic [WIDTH-1:0]  rsp_load_data_c;
  logic [FLG_W-1:0]  rsp_load_flags_c;
  logic              rsp_load_err_c;

  assign cmd_ready     = (state_q == ST_IDLE);
  assign accept_c      = cmd_valid && cmd_ready;
  assign rsp_hs_c      = rsp_valid && rsp_ready;
  assign sample_done_c = (cnt_q == CNT_W'(SAMPLE_DLY));

  always_comb begin
    alu_flags_c            = '0;
    alu_flags_c[FLG_CARRY] = alu_carry_out;
    alu_flags_c[FLG_ZERO]  = alu_zero_flag;
    alu_flags_c[FLG_VALID] = alu_valid_flag;
    alu_flags_c[FLG_SLT]   = alu_slt_flag;
  end

  // Next-state and datapath control; error responses leave the ALU pins and last_q alone.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    last_d           = last_q;
    in1_d            = in1_q;
    in2_d            = in2_q;
    op_d             = op_q;
    vld_d            = vld_q;
    rsp_load_c       = 1'b0;
    rsp_load_data_c  = '0;
    rsp_load_flags_c = '0;
    rsp_load_err_c   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          if (op_drives_alu(OP_W'(cmd_op))) begin
            in1_d   = cmd_chain ? last_q : cmd_a;
            in2_d   = cmd_b;
            op_d    = cmd_op;
            vld_d   = 1'b1;
            cnt_d   = '0;
            state_d = ST_EXEC;
          end else begin
            rsp_load_c     = 1'b1;
            rsp_load_err_c = 1'b1;
            state_d        = ST_RESP;
          end
        end
      end
      ST_EXEC: begin
        if (sample_done_c) begin
          rsp_load_c       = 1'b1;
          rsp_load_data_c  = alu_data_out;
          rsp_load_flags_c = alu_flags_c;
          last_d           = alu_data_out;
          vld_d            = 1'b0;
          state_d          = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_hs_c) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        vld_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= '0;
      in1_q   <= '0;
      in2_q   <= '0;
      op_q    <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      op_q    <= op_d;
      vld_q   <= vld_d;
    end
  end

  assign alu_data_in1   = in1_q;
  assign alu_data_in2   = in2_q;
  assign alu_op_code    = op_q;
  assign alu_valid_data = vld_q;

  alu_drv_rsp_reg #(
    .WIDTH(WIDTH)
  ) u_rsp_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (rsp_load_c),
    .load_data (rsp_load_data_c),
    .load_flags(rsp_load_flags_c),
    .load_err  (rsp_load_err_c),
    .rsp_ready (rsp_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_flags (rsp_flags),
    .rsp_err   (rsp_err)
  );

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver: two instances (SAMPLE_DLY 0 and 3), each driving a
// behavioural ALU; expected values are hand-computed constants.
module tb_alu_cmd_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  // Instance 0 (SAMPLE_DLY = 0)
  logic       c0_valid, c0_ready, c0_chain, r0_valid, r0_ready, r0_err;
  logic [2:0] c0_op, a0_op;
  logic [7:0] c0_a, c0_b, a0_in1, a0_in2, a0_out, r0_data;
  logic       a0_vld, a0_c, a0_z, a0_v, a0_s;
  logic [3:0] r0_flags;

  // Instance 1 (SAMPLE_DLY = 3)
  logic       c1_valid, c1_ready, c1_chain, r1_valid, r1_ready, r1_err;
  logic [2:0] c1_op, a1_op;
  logic [7:0] c1_a, c1_b, a1_in1, a1_in2, a1_out, r1_data;
  logic       a1_vld, a1_c, a1_z, a1_v, a1_s;
  logic [3:0] r1_flags;

  // ALU model: {data_out, carry, zero, valid, slt}; outputs are quiet while valid_data is low.
  function automatic logic [11:0] alu_f(input logic [7:0] x, input logic [7:0] y,
                                        input logic [2:0] op, input logic v);
    logic [8:0] s;
    logic [7:0] r;
    s = '0;
    case (op)
      3'd0:    s = {1'b0, x} + {1'b0, y};
      3'd1:    s = {1'b0, x} - {1'b0, y};
      3'd2:    s = {1'b0, x & y};
      3'd3:    s = {1'b0, x | y};
      3'd4:    s = {1'b0, x ^ y};
      3'd6:    s = {x, 1'b0};
      3'd7:    s = {y, 1'b0};
      default: s = '0;
    endcase
    r = s[7:0];
    if (!v) return '0;
    return {r, s[8], (r == 8'h00), (r != 8'h00), ($signed(x) < $signed(y))};
  endfunction

  always_comb {a0_out, a0_c, a0_z, a0_v, a0_s} = alu_f(a0_in1, a0_in2, a0_op, a0_vld);
  always_comb {a1_out, a1_c, a1_z, a1_v, a1_s} = alu_f(a1_in1, a1_in2, a1_op, a1_vld);

  alu_cmd_driver #(.WIDTH(8), .OPCODE(3), .SAMPLE_DLY(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(c0_valid), .cmd_ready(c0_ready), .cmd_op(c0_op),
    .cmd_a(c0_a), .cmd_b(c0_b), .cmd_chain(c0_chain),
    .alu_data_in1(a0_in1), .alu_data_in2(a0_in2), .alu_op_code(a0_op),
    .alu_valid_data(a0_vld), .alu_data_out(a0_out), .alu_carry_out(a0_c),
    .alu_zero_flag(a0_z), .alu_valid_flag(a0_v), .alu_slt_flag(a0_s),
    .rsp_valid(r0_valid), .rsp_ready(r0_ready), .rsp_data(r0_data),
    .rsp_flags(r0_flags), .rsp_err(r0_err)
  );

  alu_cmd_driver #(.WIDTH(8), .OPCODE(3), .SAMPLE_DLY(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(c1_valid), .cmd_ready(c1_ready), .cmd_op(c1_op),
    .cmd_a(c1_a), .cmd_b(c1_b), .cmd_chain(c1_chain),
    .alu_data_in1(a1_in1), .alu_data_in2(a1_in2), .alu_op_code(a1_op),
    .alu_valid_data(a1_vld), .alu_data_out(a1_out), .alu_carry_out(a1_c),
    .alu_zero_flag(a1_z), .alu_valid_flag(a1_v), .alu_slt_flag(a1_s),
    .rsp_valid(r1_valid), .rsp_ready(r1_ready), .rsp_data(r1_data),
    .rsp_flags(r1_flags), .rsp_err(r1_err)
  );

  // Clock cycles during which alu_valid_data was high, per instance.
  int vld0_cnt = 0;
  int vld1_cnt = 0;
  always @(posedge clk) begin
    if (a0_vld) vld0_cnt <= vld0_cnt + 1;
    if (a1_vld) vld1_cnt <= vld1_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one command to instance 0 (cmd_ready assumed high) and wait for rsp_valid.
  // lat counts edges from the accept edge (inclusive) to the edge raising rsp_valid.
  task automatic send0(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic chain, output int lat, output logic [7:0] in1_seen);
    c0_op = op; c0_a = a; c0_b = b; c0_chain = chain; c0_valid = 1'b1;
    @(negedge clk);
    c0_valid = 1'b0;
    in1_seen = a0_in1;
    lat = 1;
    while (!r0_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat;
    int         v;
    logic [7:0] in1;
    logic       ok;

    rst_n = 1'b0;
    c0_valid = 1'b0; c0_op = '0; c0_a = '0; c0_b = '0; c0_chain = 1'b0; r0_ready = 1'b1;
    c1_valid = 1'b0; c1_op = '0; c1_a = '0; c1_b = '0; c1_chain = 1'b0; r1_ready = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_cmd_ready", c0_ready, 1);
    chk("rst_rsp_valid", r0_valid, 0);
    chk("rst_alu_valid", a0_vld, 0);
    chk("rst_rsp_data", r0_data, 0);
    chk("rst_rsp_flags", r0_flags, 0);
    chk("rst_rsp_err", r0_err, 0);
    chk("rst_alu_in1", a0_in1, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: add F0 + 20
    v = vld0_cnt;
    send0(3'b000, 8'hF0, 8'h20, 1'b0, lat, in1);
    chk("t1_latency", lat, 2);
    chk("t1_in1", in1, 8'hF0);
    chk("t1_data", r0_data, 8'h10);
    chk("t1_flags", r0_flags, 4'b1011);
    chk("t1_err", r0_err, 0);
    chk("t1_vld_cycles", vld0_cnt - v, 1);
    chk("t1_alu_vld_low", a0_vld, 0);
    @(negedge clk);
    chk("t1_idle_ready", c0_ready, 1);
    chk("t1_rsp_dropped", r0_valid, 0);

    // 2: sub 5 - 5
    send0(3'b001, 8'h05, 8'h05, 1'b0, lat, in1);
    chk("t2_data", r0_data, 8'h00);
    chk("t2_flags", r0_flags, 4'b0100);
    @(negedge clk);

    // 3: 3 + 4, then chained + 1
    send0(3'b000, 8'h03, 8'h04, 1'b0, lat, in1);
    chk("t3_data_a", r0_data, 8'h07);
    @(negedge clk);
    send0(3'b000, 8'hAA, 8'h01, 1'b1, lat, in1);
    chk("t3_chain_in1", in1, 8'h07);
    chk("t3_chain_data", r0_data, 8'h08);
    @(negedge clk);

    // 4: reserved opcode, then chained + 2 from the last good result
    v = vld0_cnt;
    send0(3'b101, 8'h11, 8'h22, 1'b0, lat, in1);
    chk("t4_err_latency", lat, 1);
    chk("t4_err", r0_err, 1);
    chk("t4_err_data", r0_data, 0);
    chk("t4_err_flags", r0_flags, 0);
    chk("t4_err_no_alu", vld0_cnt - v, 0);
    @(negedge clk);
    send0(3'b000, 8'h55, 8'h02, 1'b1, lat, in1);
    chk("t4_chain_data", r0_data, 8'h0A);
    chk("t4_chain_err", r0_err, 0);
    @(negedge clk);

    // 5: SAMPLE_DLY = 3 with back-pressure
    chk("t5_ready_before", c1_ready, 1);
    v = vld1_cnt;
    c1_op = 3'b000; c1_a = 8'h10; c1_b = 8'h20; c1_chain = 1'b0; c1_valid = 1'b1;
    @(negedge clk);
    c1_valid = 1'b0;
    lat = 1;
    while (!r1_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("t5_latency", lat, 5);
    chk("t5_vld_cycles", vld1_cnt - v, 4);
    chk("t5_data", r1_data, 8'h30);
    chk("t5_flags", r1_flags, 4'b0011);
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (r1_valid !== 1'b1 || r1_data !== 8'h30 || r1_flags !== 4'b0011 ||
          r1_err !== 1'b0 || c1_ready !== 1'b0 || a1_vld !== 1'b0) ok = 1'b0;
    end
    chk("t5_hold_stable", ok, 1);
    r1_ready = 1'b1;
    @(negedge clk);
    chk("t5_rsp_dropped", r1_valid, 0);
    chk("t5_idle_ready", c1_ready, 1);

    // 6: reset during EXEC aborts the command and clears last_result
    c0_op = 3'b000; c0_a = 8'h01; c0_b = 8'h02; c0_chain = 1'b0; c0_valid = 1'b1;
    @(negedge clk);
    c0_valid = 1'b0;
    chk("t6_in_exec", a0_vld, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_vld", a0_vld, 0);
    chk("t6_async_rsp", r0_valid, 0);
    ok = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (r0_valid) ok = 1'b1;
    end
    chk("t6_no_response", ok, 0);
    rst_n = 1'b1;
    @(negedge clk);
    send0(3'b000, 8'hEE, 8'h05, 1'b1, lat, in1);
    chk("t6_chain_in1", in1, 8'h00);
    chk("t6_chain_data", r0_data, 8'h05);
    chk("t6_latency", lat, 2);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
